// File: rtl/trace_capture_buffer_pkg.sv
// -----------------------------------------------------------------------------
// trace_capture_buffer_pkg
// Shared types for the retired-instruction trace capture buffer.
//   XLEN           : CPU data/address width. This mirrors the CPU profile value
//                    so that the slice stands alone.
//   tracer_bus_t   : WB-stage tracer bundle for one retired instruction.
//   trace_state_e  : capture FSM state, visible on the top-level o_state port.
//   trace_entry_t  : one stored entry. It holds the tracer bundle and, when
//                    TRACE_TIMESTAMP_EN is defined, a 32-bit capture timestamp.
// -----------------------------------------------------------------------------
package trace_capture_buffer_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TS_W = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic [XLEN-1:0] rd_wdata;
  } tracer_bus_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StPost   = 2'd2,
    StFrozen = 2'd3
  } trace_state_e;

  typedef struct packed {
    tracer_bus_t     bus;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
  } trace_entry_t;

  // True when the retiring instruction's PC equals the trigger PC.
  function automatic logic pc_match(input tracer_bus_t bus, input logic [XLEN-1:0] pc);
    return bus.pc == pc;
  endfunction

endpackage

// File: rtl/trace_capture_buffer_ring_mem.sv
// -----------------------------------------------------------------------------
// trace_capture_buffer_ring_mem
// Circular entry storage with overwrite-oldest semantics.
//   i_clk, i_rst : clock and synchronous active-high reset.
//   i_clear      : clears the pointer, the count and the wrapped flag. It has
//                  priority over writes and pops.
//   i_wr_en      : write i_wr_data at the write pointer.
//   i_wr_data    : entry to store.
//   i_pop        : consume the oldest entry. It is ignored when the buffer is
//                  empty.
//   o_rd_data    : oldest held entry, read combinationally from storage.
//   o_count      : number of entries held. It saturates at DEPTH.
//   o_wrapped    : set when at least one entry has been overwritten since the
//                  last clear.
// The storage array has no reset. Only the bookkeeping registers are cleared.
// -----------------------------------------------------------------------------
module trace_capture_buffer_ring_mem
  import trace_capture_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  trace_entry_t     i_wr_data,
  input  logic             i_pop,
  output trace_entry_t     o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrapped
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  trace_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_wrapped;
  logic [PTR_W-1:0] w_rd_idx;
  logic             w_full;

  assign w_full = (r_count == CNT_W'(DEPTH));

  // The oldest entry sits count slots behind the write pointer. When the
  // buffer is full, the low count bits are zero and the index equals wr_ptr.
  assign w_rd_idx = r_wr_ptr - r_count[PTR_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_wr_en && !i_clear && !i_rst) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (i_wr_en) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_full) begin
        r_wrapped <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_rd_data = r_mem[w_rd_idx];
  assign o_count   = r_count;
  assign o_wrapped = r_wrapped;

endmodule

// File: rtl/trace_capture_buffer.sv
// -----------------------------------------------------------------------------
// trace_capture_buffer
// Records retired instructions from the WB-stage tracer bus into a circular
// buffer. Capture stops on a PC-match trigger, after a programmable
// post-trigger window, or on a manual freeze. Frozen contents drain
// oldest-first over a valid/ready port.
//   i_clk, i_rst      : clock and synchronous active-high reset.
//   i_wb_valid        : i_wb_trace holds a retiring instruction this cycle.
//   i_wb_trace        : WB-stage trace bundle.
//   i_arm             : pulse that clears the buffer and starts recording.
//   i_force_freeze    : pulse that stops recording. It applies in ARMED and
//                       POST only.
//   i_trig_en         : enables the PC-match trigger.
//   i_trig_pc         : trigger PC.
//   i_post_count      : number of entries captured after the trigger entry.
//   i_rd_ready        : the consumer accepts o_rd_entry.
//   o_rd_valid        : o_rd_entry holds the oldest unread entry.
//   o_rd_entry        : oldest entry. It is '0 when o_rd_valid is low.
//   o_state           : current FSM state.
//   o_entry_count     : number of entries currently held.
//   o_wrapped         : an entry was overwritten since the last arm.
//   o_rd_timestamp    : capture cycle of o_rd_entry. This port exists only
//                       when TRACE_TIMESTAMP_EN is defined.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a free-running 32-bit cycle
// counter. Its value is stored with each entry and shown on o_rd_timestamp.
// -----------------------------------------------------------------------------
module trace_capture_buffer
  import trace_capture_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wb_valid,
  input  tracer_bus_t      i_wb_trace,
  input  logic             i_arm,
  input  logic             i_force_freeze,
  input  logic             i_trig_en,
  input  logic [XLEN-1:0]  i_trig_pc,
  input  logic [CNT_W-1:0] i_post_count,
  input  logic             i_rd_ready,
  output logic             o_rd_valid,
  output tracer_bus_t      o_rd_entry,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]  o_rd_timestamp,
`endif
  output trace_state_e     o_state,
  output logic [CNT_W-1:0] o_entry_count,
  output logic             o_wrapped
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("trace_capture_buffer: DEPTH must be a power of two and at least 2");
  end

  trace_state_e     r_state;
  logic [CNT_W-1:0] r_post;
  logic             w_recording;
  logic             w_wr_en;
  logic             w_trig_hit;
  logic             w_rd_valid;
  logic             w_pop;
  logic [CNT_W-1:0] w_count;
  logic             w_wrapped;
  trace_entry_t     w_wr_data;
  trace_entry_t     w_rd_data;

  assign w_recording = (r_state == StArmed) || (r_state == StPost);
  // An arm in the same cycle wins, so that cycle's retirement is dropped.
  assign w_wr_en     = w_recording && i_wb_valid && !i_arm;
  assign w_trig_hit  = (r_state == StArmed) && i_wb_valid && i_trig_en &&
                       pc_match(i_wb_trace, i_trig_pc);
  assign w_rd_valid  = (r_state == StFrozen) && (w_count != '0);
  assign w_pop       = w_rd_valid && i_rd_ready;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_cycle;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + TS_W'(1);
    end
  end
`endif

  always_comb begin
    w_wr_data     = '0;
    w_wr_data.bus = i_wb_trace;
`ifdef TRACE_TIMESTAMP_EN
    w_wr_data.ts  = r_cycle;
`endif
  end

  trace_capture_buffer_ring_mem #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ring_mem (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (i_arm),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_wrapped (w_wrapped)
  );

  // Capture FSM. r_post counts the writes that remain in the post-trigger
  // window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_post  <= '0;
    end else if (i_arm) begin
      r_state <= StArmed;
      r_post  <= '0;
    end else begin
      unique case (r_state)
        StIdle: ;
        StArmed: begin
          if (i_force_freeze) begin
            r_state <= StFrozen;
          end else if (w_trig_hit) begin
            if (i_post_count == '0) begin
              r_state <= StFrozen;
            end else begin
              r_state <= StPost;
              r_post  <= i_post_count;
            end
          end
        end
        StPost: begin
          if (i_force_freeze) begin
            r_state <= StFrozen;
          end else if (i_wb_valid) begin
            r_post <= r_post - CNT_W'(1);
            // This write is the last one in the window.
            if (r_post == CNT_W'(1)) begin
              r_state <= StFrozen;
            end
          end
        end
        StFrozen: ;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rd_valid    = w_rd_valid;
  assign o_rd_entry    = w_rd_valid ? w_rd_data.bus : '0;
`ifdef TRACE_TIMESTAMP_EN
  assign o_rd_timestamp = w_rd_valid ? w_rd_data.ts : '0;
`endif
  assign o_state       = r_state;
  assign o_entry_count = w_count;
  assign o_wrapped     = w_wrapped;

endmodule

// File: tb/tb_trace_capture_buffer.sv
module tb_trace_capture_buffer;
  import trace_capture_buffer_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid;
  tracer_bus_t      wb_trace;
  logic             arm;
  logic             force_freeze;
  logic             trig_en;
  logic [XLEN-1:0]  trig_pc;
  logic [CNT_W-1:0] post_count;
  logic             rd_ready;
  logic             rd_valid;
  tracer_bus_t      rd_entry;
  trace_state_e     state;
  logic [CNT_W-1:0] entry_count;
  logic             wrapped;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]      rd_ts;
  logic [31:0]      tb_cyc;
  logic [31:0]      exp_ts0;
  logic [31:0]      exp_ts1;
  logic [31:0]      obs_ts0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef TRACE_TIMESTAMP_EN
  // Reference cycle counter, advanced with the same rule as the DUT's.
  always @(posedge clk) tb_cyc <= rst ? 32'd0 : tb_cyc + 32'd1;
`endif

  trace_capture_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wb_valid     (wb_valid),
    .i_wb_trace     (wb_trace),
    .i_arm          (arm),
    .i_force_freeze (force_freeze),
    .i_trig_en      (trig_en),
    .i_trig_pc      (trig_pc),
    .i_post_count   (post_count),
    .i_rd_ready     (rd_ready),
    .o_rd_valid     (rd_valid),
    .o_rd_entry     (rd_entry),
`ifdef TRACE_TIMESTAMP_EN
    .o_rd_timestamp (rd_ts),
`endif
    .o_state        (state),
    .o_entry_count  (entry_count),
    .o_wrapped      (wrapped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    wb_trace          = '0;
    wb_trace.pc       = pc;
    wb_trace.insn     = pc ^ 32'h0000_0013;
    wb_trace.rd_addr  = pc[6:2];
    wb_trace.rd_we    = 1'b1;
    wb_trace.rd_wdata = ~pc;
  endtask

  task automatic retire(input logic [31:0] pc);
    set_pc(pc);
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_freeze();
    force_freeze = 1'b1;
    tick();
    force_freeze = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_trace = '0; arm = 1'b0; force_freeze = 1'b0;
    trig_en = 1'b0; trig_pc = '0; post_count = '0; rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_state", 32'(state), 32'(StIdle));
    chk("rst_count", 32'(entry_count), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_entry", rd_entry.pc, 32'd0);

    // IDLE ignores retirements
    retire(32'h40);
    chk("idle_count", 32'(entry_count), 32'd0);

    // Five retirements, then a manual freeze and an ordered drain
    do_arm();
    chk("t1_armed", 32'(state), 32'(StArmed));
    for (int i = 0; i < 5; i++) retire(32'(4 * i));
    chk("t1_count_pre", 32'(entry_count), 32'd5);
    do_freeze();
    chk("t1_frozen", 32'(state), 32'(StFrozen));
    chk("t1_count", 32'(entry_count), 32'd5);
    chk("t1_wrapped", 32'(wrapped), 32'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t1_rd_valid", 32'(rd_valid), 32'd1);
      chk("t1_rd_pc", rd_entry.pc, 32'(4 * i));
      chk("t1_rd_insn", rd_entry.insn, 32'(4 * i) ^ 32'h13);
      tick();
    end
    chk("t1_empty_valid", 32'(rd_valid), 32'd0);
    chk("t1_empty_count", 32'(entry_count), 32'd0);
    chk("t1_empty_entry", rd_entry.pc, 32'd0);
    tick();
    chk("t1_empty_state", 32'(state), 32'(StFrozen));
    rd_ready = 1'b0;

    // Twenty retirements into sixteen slots: the oldest four are lost
    do_arm();
    for (int i = 0; i < 20; i++) retire(32'(4 * i));
    do_freeze();
    chk("t2_count", 32'(entry_count), 32'd16);
    chk("t2_wrapped", 32'(wrapped), 32'd1);
    chk("t2_first_pc", rd_entry.pc, 32'h10);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_rd_pc", rd_entry.pc, 32'h10 + 32'(4 * i));
      tick();
    end
    chk("t2_empty_valid", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;

    // PC trigger with a post-trigger window of three entries
    trig_en = 1'b1; trig_pc = 32'h100; post_count = CNT_W'(3);
    do_arm();
    for (int i = 0; i < 6; i++) begin
      retire(32'hF8 + 32'(4 * i));
      if (i == 2) chk("t3_post", 32'(state), 32'(StPost));
    end
    chk("t3_frozen", 32'(state), 32'(StFrozen));
    retire(32'h110);
    chk("t3_count", 32'(entry_count), 32'd6);
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t3_rd_pc", rd_entry.pc, 32'hF8 + 32'(4 * i));
      tick();
    end
    chk("t3_empty_valid", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;

    // Trigger with post_count=0 freezes right after the trigger write
    trig_pc = 32'h40; post_count = '0;
    do_arm();
    retire(32'h38);
    retire(32'h3C);
    chk("t4_armed", 32'(state), 32'(StArmed));
    retire(32'h40);
    chk("t4_frozen", 32'(state), 32'(StFrozen));
    chk("t4_count", 32'(entry_count), 32'd3);
    rd_ready = 1'b1;
    tick();
    tick();
    chk("t4_newest_pc", rd_entry.pc, 32'h40);
    rd_ready = 1'b0;
    trig_en = 1'b0;

    // Handshake with rd_ready held low in the middle cycle
    do_arm();
    for (int i = 0; i < 4; i++) retire(32'h200 + 32'(4 * i));
    do_freeze();
    chk("t5_count4", 32'(entry_count), 32'd4);
    rd_ready = 1'b1; tick();
    rd_ready = 1'b0; tick();
    rd_ready = 1'b1; tick();
    rd_ready = 1'b0;
    chk("t5_count2", 32'(entry_count), 32'd2);
    chk("t5_rd_pc", rd_entry.pc, 32'h208);
    // An arm wins over a retirement in the same cycle
    arm = 1'b1; set_pc(32'h500); wb_valid = 1'b1;
    tick();
    arm = 1'b0; wb_valid = 1'b0;
    chk("t5_arm_count", 32'(entry_count), 32'd0);
    chk("t5_arm_state", 32'(state), 32'(StArmed));

    // Reset in the middle of the post-trigger window
    trig_en = 1'b1; trig_pc = 32'h300; post_count = CNT_W'(5);
    for (int i = 0; i < 7; i++) retire(32'h2F8 + 32'(4 * i));
    chk("t6_post", 32'(state), 32'(StPost));
    chk("t6_count7", 32'(entry_count), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    trig_en = 1'b0;
    chk("t6_rst_state", 32'(state), 32'(StIdle));
    chk("t6_rst_count", 32'(entry_count), 32'd0);
    chk("t6_rst_valid", 32'(rd_valid), 32'd0);

    // A force_freeze in IDLE has no effect
    do_freeze();
    chk("t7_idle_freeze", 32'(state), 32'(StIdle));

`ifdef TRACE_TIMESTAMP_EN
    // Timestamps of captures on back-to-back cycles
    do_arm();
    set_pc(32'h0); wb_valid = 1'b1; exp_ts0 = tb_cyc;
    tick();
    set_pc(32'h4); exp_ts1 = tb_cyc;
    tick();
    wb_valid = 1'b0;
    do_freeze();
    chk("ts_first", rd_ts, exp_ts0);
    obs_ts0 = rd_ts;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("ts_second", rd_ts, exp_ts1);
    chk("ts_delta", rd_ts - obs_ts0, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Sequential successor to the combinational pipeline trace taps.
- Records retired instructions from the WB-stage tracer bus into a parametrised circular buffer.
- Supports a PC-match trigger, a programmable post-trigger window and manual freeze.
- Frozen contents drain oldest-first over a valid/ready port, to a testbench monitor or a future debug-bus bridge.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2 (elaboration-time assertion).
- CNT_W, $clog2(DEPTH+1), width of the count and post-trigger fields.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- wb_valid  in  1  wb_trace holds a retiring instruction this cycle.
- wb_trace  in  tracer_bus_t  WB-stage trace bundle.
- arm  in  1  pulse; clears the buffer and starts recording.
- force_freeze  in  1  pulse; stops recording.
- trig_en  in  1  enables the PC-match trigger.
- trig_pc  in  XLEN  trigger PC.
- post_count  in  CNT_W  entries captured after the trigger entry; sampled when the trigger fires.
- rd_ready  in  1  consumer accepts rd_entry.
- rd_valid  out  1  rd_entry holds the oldest unread entry.
- rd_entry  out  tracer_bus_t  oldest entry.
- state  out  trace_state_e  current FSM state.
- entry_count  out  CNT_W  entries currently held.
- wrapped  out  1  at least one entry was overwritten since the last arm.

Behaviour:
- Reset: state=IDLE, wr_ptr=0, entry_count=0, wrapped=0, post counter=0, rd_valid=0, rd_entry='0. Reset mid-capture or mid-drain discards everything. Storage array is not cleared.
- States: IDLE, ARMED, POST, FROZEN. Recording happens only in ARMED and POST.
- Arm: arm=1 in any state (highest priority after rst) → next state ARMED; wr_ptr, entry_count, wrapped and post counter cleared. A wb_valid in the same cycle is not captured.
- Write (ARMED/POST, wb_valid=1):
  - mem[wr_ptr] <= wb_trace.
  - wr_ptr wraps modulo DEPTH.
  - entry_count increments, saturating at DEPTH.
  - A write at entry_count==DEPTH overwrites the oldest entry and sets wrapped=1.
- Trigger (ARMED, wb_valid && trig_en && wb_trace.pc==trig_pc):
  - The triggering entry is written.
  - post_count==0 → FROZEN next cycle.
  - Otherwise → POST, post counter=post_count.
- POST: each write decrements the counter; the write that brings it to 0 is captured, then state → FROZEN.
- force_freeze in ARMED/POST → FROZEN. A same-cycle write is still captured. force_freeze in IDLE/FROZEN is ignored.
- force_freeze and trigger in the same cycle → FROZEN.
- Readout (FROZEN only):
  - rd_valid = (entry_count!=0).
  - rd_entry = mem[(wr_ptr - entry_count) mod DEPTH], combinational from storage. Outside FROZEN, or when rd_valid=0, rd_entry='0.
  - Transfer on rd_valid && rd_ready: entry_count decrements next cycle; wr_ptr is unchanged.
  - Empty: rd_valid=0, state stays FROZEN until arm.
  - rd_ready with rd_valid=0 has no effect.
- Latency: a capture is visible in entry_count one cycle after the wb_valid cycle. Each read is zero-latency on the handshake; one entry per cycle max.
- IDLE: wb_valid ignored, rd_valid=0.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - 32-bit free-running cycle counter, reset to 0, wraps at 2^32.
  - Its value is stored with every captured entry.
  - Extra output rd_timestamp (32 bits) is aligned with rd_entry and is '0 when rd_valid=0.
- Undefined: no counter, no timestamp storage, rd_timestamp port absent.

Decomposition:
- tracer package gets trace_state_e (IDLE/ARMED/POST/FROZEN) and trace_entry_t (tracer_bus_t plus optional timestamp).
- XLEN stays in CPU_profile.
- Sub-module trace_ring_mem holds the storage array, wr_ptr, entry_count, wrapped and oldest-entry read indexing.
- The top level holds the FSM, trigger compare and post counter.

Test Plan:
- DEPTH=16; arm, then 5 wb_valid with pc 0x0,0x4,…,0x10, then force_freeze → entry_count=5, wrapped=0, rd_ready=1 drains pc 0x0..0x10 in order, then rd_valid=0.
- DEPTH=16; arm, 20 retirements pc 0x0..0x4C, freeze → entry_count=16, wrapped=1, first read pc=0x10, last 0x4C.
- trig_en=1, trig_pc=0x100, post_count=3; retire pc 0xF8,0xFC,0x100,0x104,0x108,0x10C,0x110 → FROZEN after 0x10C; 0x110 not captured; last read 0x10C.
- trig_pc hit with post_count=0 → FROZEN the cycle after the trigger write; newest entry is the trigger PC.
- FROZEN with 4 entries, rd_ready toggled 1,0,1 → exactly 2 transfers, entry_count=2; arm plus wb_valid in the same cycle → entry_count=0, state=ARMED.
- rst asserted mid-POST with 7 entries → next cycle state=IDLE, entry_count=0, rd_valid=0. With TRACE_TIMESTAMP_EN, timestamps of consecutive-cycle captures differ by exactly 1.
